// File: rtl/queue_ctrl.sv
// queue_ctrl: front end of the bank-queue people counter.
// Both photocell levels are synchronized, debounced and edge-detected. The
// resulting entry and exit events drive a saturating occupancy count. A small
// scheduler runs a restoring divider that estimates the wait time as
// SVC*(pcount+tcount-1)/tcount whenever the operands change.
// Build option: define QUEUE_CTRL_ERR_EN to get sticky err_ovf/err_unf flags;
// otherwise both ports are tied low.
module queue_ctrl #(
    parameter int unsigned N   = 3,
    parameter int unsigned T_W = 2,
    parameter int unsigned DEB = 2,
    parameter int unsigned SVC = 3,
    parameter int unsigned W_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           photo_in,
    input  logic           photo_out,
    input  logic [T_W-1:0] tcount,
    output logic [N-1:0]   pcount,
    output logic           full,
    output logic           empty,
    output logic [W_W-1:0] wtime,
    output logic           wvalid,
    output logic           busy,
    output logic           err_ovf,
    output logic           err_unf
);

    localparam int unsigned DebW = (DEB > 1) ? $clog2(DEB + 1) : 1;
    localparam int unsigned CntW = (W_W > 1) ? $clog2(W_W) : 1;

    localparam logic [N-1:0] PMax      = '1;
    localparam logic [N-1:0] PNearFull = {{(N - 1){1'b1}}, 1'b0};
    localparam logic [N-1:0] POne      = {{(N - 1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Sensor conditioning. Bit 0 is the entry channel, bit 1 the exit one.
    // ------------------------------------------------------------------
    logic [1:0]           raw;
    logic [1:0]           s1_q;
    logic [1:0]           s2_q;
    logic [1:0]           filt_q;
    logic [1:0]           filt_prev_q;
    logic [1:0][DebW-1:0] deb_cnt_q;
    logic [1:0]           evt;

    assign raw = {photo_out, photo_in};

    // Synchronize, then accept a new level only after DEB consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            deb_cnt_q   <= '0;
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebW'(DEB - 1)) begin
                    filt_q[i]    <= s2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // One-cycle pulse on each rising edge of the filtered level.
    assign evt = filt_q & ~filt_prev_q;

    // ------------------------------------------------------------------
    // Occupancy count.
    // ------------------------------------------------------------------
    logic ent_only;
    logic ext_only;

    // Simultaneous entry and exit cancel out.
    assign ent_only = evt[0] & ~evt[1];
    assign ext_only = evt[1] & ~evt[0];

    // Saturating up/down count; full/empty are registered with it so all
    // three always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcount <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (ent_only && !full) begin
            pcount <= pcount + 1'b1;
            full   <= (pcount == PNearFull);
            empty  <= 1'b0;
        end else if (ext_only && !empty) begin
            pcount <= pcount - 1'b1;
            full   <= 1'b0;
            empty  <= (pcount == POne);
        end
    end

`ifdef QUEUE_CTRL_ERR_EN
    logic err_ovf_q;
    logic err_unf_q;

    // Sticky flags for rejected entry (while full) and exit (while empty).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (ent_only && full) begin
                err_ovf_q <= 1'b1;
            end
            if (ext_only && empty) begin
                err_unf_q <= 1'b1;
            end
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Wait-time divider and its scheduler.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StLoad, StDiv, StDone} state_e;

    state_e          state_q;
    logic [N-1:0]    snap_p_q;
    logic [T_W-1:0]  snap_t_q;
    logic [W_W-1:0]  quo_q;      // numerator shifts out the top, quotient in
    logic [T_W-1:0]  rem_q;
    logic [T_W-1:0]  dvs_q;
    logic [CntW-1:0] step_q;

    logic            opnd_chg;
    logic [W_W-1:0]  num_calc;
    logic [T_W:0]    trial;
    logic [T_W:0]    diff;
    logic            ge;

    assign opnd_chg = (pcount != snap_p_q) || (tcount != snap_t_q);

    // The numerator always fits W_W bits for legal parameter choices.
    assign num_calc = W_W'(SVC * (32'(snap_p_q) + 32'(snap_t_q) - 32'd1));

    // Restoring step: bring down the next numerator bit and try a subtract.
    assign trial = {rem_q, quo_q[W_W-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign ge    = (trial >= {1'b0, dvs_q});

    // Scheduler: snapshot operands, special-case zero operands, otherwise
    // run W_W divide steps; any operand change before DONE restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            snap_p_q <= '0;
            snap_t_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            step_q   <= '0;
            wtime    <= '0;
            wvalid   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wvalid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (opnd_chg) begin
                        snap_p_q <= pcount;
                        snap_t_q <= tcount;
                        busy     <= 1'b1;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    if (opnd_chg) begin
                        snap_p_q <= pcount;
                        snap_t_q <= tcount;
                        state_q  <= StLoad;
                    end else if (snap_p_q == '0) begin
                        quo_q   <= '0;
                        state_q <= StDone;
                    end else if (snap_t_q == '0) begin
                        quo_q   <= '1;
                        state_q <= StDone;
                    end else begin
                        quo_q   <= num_calc;
                        rem_q   <= '0;
                        dvs_q   <= snap_t_q;
                        step_q  <= CntW'(W_W - 1);
                        state_q <= StDiv;
                    end
                end
                StDiv: begin
                    if (opnd_chg) begin
                        snap_p_q <= pcount;
                        snap_t_q <= tcount;
                        state_q  <= StLoad;
                    end else begin
                        quo_q <= {quo_q[W_W-2:0], ge};
                        rem_q <= T_W'(ge ? diff : trial);
                        if (step_q == '0) begin
                            state_q <= StDone;
                        end else begin
                            step_q <= step_q - 1'b1;
                        end
                    end
                end
                StDone: begin
                    wtime   <= quo_q;
                    wvalid  <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queue_ctrl.sv
// Self-checking bench for queue_ctrl: a cycle-level behavioural model built
// from sample histories, a saturating integer count and a countdown-based
// divide scheduler, compared against the DUT every cycle, plus directed
// scenarios with hand-computed expectations and a randomized soak.
module tb_queue_ctrl;

    localparam int unsigned N    = 3;
    localparam int unsigned T_W  = 2;
    localparam int unsigned DEB  = 2;
    localparam int unsigned SVC  = 3;
    localparam int unsigned W_W  = 5;
    localparam int unsigned PMAX = (1 << N) - 1;
    localparam int unsigned ALL1 = (1 << W_W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           photo_in = 1'b0;
    logic           photo_out = 1'b0;
    logic [T_W-1:0] tcount = '0;
    logic [N-1:0]   pcount;
    logic           full;
    logic           empty;
    logic [W_W-1:0] wtime;
    logic           wvalid;
    logic           busy;
    logic           err_ovf;
    logic           err_unf;

    queue_ctrl #(
        .N   (N),
        .T_W (T_W),
        .DEB (DEB),
        .SVC (SVC),
        .W_W (W_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .photo_in  (photo_in),
        .photo_out (photo_out),
        .tcount    (tcount),
        .pcount    (pcount),
        .full      (full),
        .empty     (empty),
        .wtime     (wtime),
        .wvalid    (wvalid),
        .busy      (busy),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait-time rule straight from the arithmetic definition.
    function automatic int unsigned exp_result(input int unsigned p, input int unsigned t);
        if (p == 0) return 0;
        if (t == 0) return ALL1;
        return (SVC * (p + t - 1)) / t;
    endfunction

    // Edges from operand capture to the wvalid edge.
    function automatic int unsigned run_len(input int unsigned p, input int unsigned t);
        return (p == 0 || t == 0) ? 2 : W_W + 2;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_on = 1'b0;
    int unsigned m_p;
    bit          m_ovf;
    bit          m_unf;
    bit [1:0]    m_f;
    bit [1:0]    m_pend;
    bit [DEB:0]  m_hist [2];   // [0] = raw seen at previous edge, [j] = j+1 edges ago
    bit          m_run;
    int unsigned m_r;
    int unsigned m_sp;
    int unsigned m_st;
    int unsigned m_wtime;
    bit          m_wvalid;

    always @(posedge clk) begin
        logic [1:0] raw;
        bit         differ;
        raw = {photo_out, photo_in};
        if (rst) begin
            m_on     = 1'b1;
            m_p      = 0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_f      = '0;
            m_pend   = '0;
            m_hist[0] = '0;
            m_hist[1] = '0;
            m_run    = 1'b0;
            m_r      = 0;
            m_sp     = 0;
            m_st     = 0;
            m_wtime  = 0;
            m_wvalid = 1'b0;
        end else if (m_on) begin
            m_wvalid = 1'b0;
            // Scheduler sees the operands as they stood before this edge.
            if (!m_run) begin
                if (m_p != m_sp || int'(tcount) != m_st) begin
                    m_sp  = m_p;
                    m_st  = int'(tcount);
                    m_run = 1'b1;
                    m_r   = run_len(m_sp, m_st);
                end
            end else if (m_r > 1 && (m_p != m_sp || int'(tcount) != m_st)) begin
                m_sp = m_p;
                m_st = int'(tcount);
                m_r  = run_len(m_sp, m_st);
            end else begin
                m_r--;
                if (m_r == 0) begin
                    m_run    = 1'b0;
                    m_wtime  = exp_result(m_sp, m_st);
                    m_wvalid = 1'b1;
                end
            end
            // Events detected at the previous edge move the count now.
            if (m_pend[0] && !m_pend[1]) begin
                if (m_p == PMAX) m_ovf = 1'b1;
                else m_p++;
            end else if (m_pend[1] && !m_pend[0]) begin
                if (m_p == 0) m_unf = 1'b1;
                else m_p--;
            end
            // Filter flips once the last DEB synchronized samples all disagree.
            for (int ch = 0; ch < 2; ch++) begin
                differ = 1'b1;
                for (int j = 1; j <= DEB; j++) begin
                    if (m_hist[ch][j] == m_f[ch]) differ = 1'b0;
                end
                m_pend[ch] = differ && !m_f[ch];
                if (differ) m_f[ch] = ~m_f[ch];
                for (int j = DEB; j > 0; j--) m_hist[ch][j] = m_hist[ch][j-1];
                m_hist[ch][0] = raw[ch];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int wv_cnt   = 0;
    int wv15_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (m_on) begin
            chk("pcount", int'(pcount), m_p);
            chk("full", int'(full), int'(m_p == PMAX));
            chk("empty", int'(empty), int'(m_p == 0));
            chk("wtime", int'(wtime), m_wtime);
            chk("wvalid", int'(wvalid), int'(m_wvalid));
            chk("busy", int'(busy), int'(m_run));
`ifdef QUEUE_CTRL_ERR_EN
            chk("err_ovf", int'(err_ovf), int'(m_ovf));
            chk("err_unf", int'(err_unf), int'(m_unf));
`else
            chk("err_ovf", int'(err_ovf), 0);
            chk("err_unf", int'(err_unf), 0);
`endif
        end
        if (wvalid) wv_cnt++;
        if (wvalid && wtime == 15) wv15_cnt++;
        if (busy) busy_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic e, input logic x, input int w, input int gap);
        photo_in  = e;
        photo_out = x;
        cyc(w);
        photo_in  = 1'b0;
        photo_out = 1'b0;
        cyc(gap);
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!busy && n < budget) begin
            cyc(1);
            n++;
        end
        chk("wait_busy", int'(busy), 1);
    endtask

    task automatic do_reset(input logic [T_W-1:0] t);
        rst    = 1'b1;
        tcount = t;
        cyc(2);
        rst = 1'b0;
        cyc(4);
    endtask

    int w0;
    int f0;
    int b0;

    initial begin
        // Reset with no tellers.
        rst = 1'b1;
        tcount = '0;
        cyc(3);
        chk("rst_pcount", int'(pcount), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_wtime", int'(wtime), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc(2);

        // Clean 6-cycle entry: count moves DEB+2 edges after the first sample.
        photo_in = 1'b1;
        cyc(4);
        chk("entry_early", int'(pcount), 0);
        cyc(1);
        chk("entry_pcount", int'(pcount), 1);
        chk("entry_empty", int'(empty), 0);
        cyc(1);
        photo_in = 1'b0;
        cyc(1);
        chk("t0_wvalid_early", int'(wvalid), 0);
        cyc(1);
        chk("t0_wvalid", int'(wvalid), 1);
        chk("t0_wtime", int'(wtime), 31);
        cyc(6);

        // One-cycle glitch is rejected.
        w0 = wv_cnt;
        pulse(1'b1, 1'b0, 1, 14);
        chk("glitch_pcount", int'(pcount), 1);
        chk("glitch_wvalid", wv_cnt - w0, 0);

        // Two tellers, three customers: 3*4/2 = 6.
        do_reset(2'd2);
        pulse(1'b1, 1'b0, 4, 14);
        pulse(1'b1, 1'b0, 4, 14);
        b0 = busy_cnt;
        pulse(1'b1, 1'b0, 4, 16);
        chk("three_pcount", int'(pcount), 3);
        chk("three_wtime", int'(wtime), 6);
        chk("three_busy_len", busy_cnt - b0, W_W + 2);

        // Saturation at 7 with three tellers: 3*9/3 = 9.
        do_reset(2'd3);
        repeat (8) pulse(1'b1, 1'b0, 4, 14);
        cyc(6);
        chk("sat_pcount", int'(pcount), 7);
        chk("sat_full", int'(full), 1);
        chk("sat_wtime", int'(wtime), 9);
`ifdef QUEUE_CTRL_ERR_EN
        chk("sat_err_ovf", int'(err_ovf), 1);
`else
        chk("sat_err_ovf", int'(err_ovf), 0);
`endif

        // Simultaneous entry and exit at 4 cancel and start no run.
        do_reset(2'd1);
        repeat (4) pulse(1'b1, 1'b0, 4, 14);
        cyc(6);
        b0 = busy_cnt;
        pulse(1'b1, 1'b1, 4, 14);
        chk("both_pcount", int'(pcount), 4);
        chk("both_nobusy", busy_cnt - b0, 0);

        // Exit from empty holds at 0.
        do_reset(2'd1);
        pulse(1'b0, 1'b1, 4, 14);
        chk("unf_pcount", int'(pcount), 0);
`ifdef QUEUE_CTRL_ERR_EN
        chk("unf_err", int'(err_unf), 1);
`else
        chk("unf_err", int'(err_unf), 0);
`endif

        // Abort: tcount 1 -> 2 mid-divide at pcount 5; only 9 is reported.
        do_reset(2'd1);
        repeat (4) pulse(1'b1, 1'b0, 4, 14);
        cyc(6);
        w0 = wv_cnt;
        f0 = wv15_cnt;
        photo_in = 1'b1;
        cyc(4);
        photo_in = 1'b0;
        wait_busy(20);
        cyc(2);
        tcount = 2'd2;
        cyc(20);
        chk("abort_pcount", int'(pcount), 5);
        chk("abort_wv_count", wv_cnt - w0, 1);
        chk("abort_wtime", int'(wtime), 9);
        chk("abort_no15", wv15_cnt - f0, 0);

        // Reset mid-divide: no wvalid, outputs back to reset values.
        w0 = wv_cnt;
        photo_in = 1'b1;
        cyc(4);
        photo_in = 1'b0;
        wait_busy(20);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_wv", wv_cnt - w0, 0);
        chk("mid_rst_pcount", int'(pcount), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_wtime", int'(wtime), 0);
        chk("mid_rst_empty", int'(empty), 1);
        rst = 1'b0;
        w0 = wv_cnt;
        cyc(10);
        chk("post_rst_wv", wv_cnt - w0, 1);
        chk("post_rst_wtime", int'(wtime), 0);

        // Randomized soak.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) photo_in = ~photo_in;
            if ($urandom_range(0, 7) == 0) photo_out = ~photo_out;
            if ($urandom_range(0, 99) == 0) begin
                photo_in  = 1'b1;
                photo_out = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) tcount = T_W'($urandom_range(0, 3));
            rst = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
- Front-end controller for the bank-queue people counter.
- Conditions the raw entry and exit photocell levels: 2-flop sync, then debounce, then rising-edge detect.
- Arbitrates entry and exit events into one saturating occupancy count (Pcount).
- Schedules a multicycle restoring divider that produces the estimated wait time Wtime = SVC*(Pcount+Tcount-1)/Tcount for the display stage.

Parameters:
- N, 3: Pcount width; maximum occupancy is 2**N-1.
- T_W, 2: Tcount (active tellers) width.
- DEB, 2: consecutive cycles a synchronized level must differ from the filtered level before it is accepted.
- SVC, 3: service time per customer, in minutes.
- W_W, 5: Wtime width; must hold SVC*(2**N+2**T_W-3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- photo_in  in  1  raw entry photocell level; asynchronous, may bounce.
- photo_out  in  1  raw exit photocell level; asynchronous, may bounce.
- tcount  in  T_W  number of active tellers; synchronous to clk.
- pcount  out  N  current occupancy.
- full  out  1  high when pcount == 2**N-1.
- empty  out  1  high when pcount == 0.
- wtime  out  W_W  last completed wait-time result.
- wvalid  out  1  one-cycle pulse when wtime updates.
- busy  out  1  divider running.
- err_ovf  out  1  sticky; entry attempted while full (optional feature).
- err_unf  out  1  sticky; exit attempted while empty (optional feature).

Behaviour:
- Reset values (rst sampled high): pcount=0, full=0, empty=1, wtime=0, wvalid=0, busy=0, err_*=0. Sync, filter and debounce registers clear to 0. Operand snapshot clears to {0,0}.
- Sensor path (per channel):
  - s1/s2 synchronizer.
  - Debounce counter counts up while s2 != filtered level f, and clears when s2 == f. When it reaches DEB, f <= s2 and the counter clears.
  - Event is a 1-cycle pulse on f rising.
  - If the input is first sampled high by s1 at edge E, pcount updates at edge E+DEB+2.
  - Glitches shorter than DEB cycles at s2 produce no event.
- Count update, in the cycle after the events:
  - Entry and exit in the same cycle: no change, no error.
  - Entry only: pcount+1, unless full, in which case hold and set err_ovf.
  - Exit only: pcount-1, unless empty, in which case hold and set err_unf.
  - pcount never wraps.
- full and empty are registered alongside pcount, so they are consistent with pcount in the same cycle.
- Divider scheduler FSM, states IDLE, LOAD, DIV, DONE:
  - IDLE: when {pcount,tcount} != snapshot, capture the snapshot and go to LOAD.
  - LOAD: compute the numerator.
    - pcount==0: numerator is 0, result 0.
    - tcount==0 with pcount!=0: result is all-ones.
    - Both special cases go straight to DONE.
    - Otherwise numerator = SVC*(pcount+tcount-1), divisor = tcount, go to DIV.
  - DIV: one quotient bit per cycle, W_W cycles. The remainder is discarded (truncating division).
  - DONE: wtime <= quotient, wvalid=1 for one cycle, back to IDLE.
  - busy=1 in LOAD, DIV and DONE.
  - Operand change during LOAD or DIV: abort, recapture the snapshot, re-enter LOAD on the next edge. wtime keeps its old value and wvalid is not pulsed for the aborted run.
  - Latency from the snapshot change to wvalid: W_W+2 cycles for a full divide, 2 cycles for the special cases.
- rst mid-divide: all state returns to reset values on that edge and no wvalid is produced. After rst is released, a nonzero tcount triggers a run that yields wtime=0, because pcount==0.

Optional Feature:
- Macro QUEUE_CTRL_ERR_EN.
- Defined: err_ovf and err_unf are sticky registers. They are set as described under Behaviour and cleared only by rst.
- Undefined: both ports stay present and are tied to 0; no error registers are synthesized. Saturation behaviour is identical in both builds.

Test Plan:
- Reset with tcount=0, then a clean photo_in pulse 6 cycles wide -> pcount becomes 1 exactly DEB+2 edges after the s1 sample. empty falls. wtime becomes all-ones (31) after 2 cycles with a wvalid pulse.
- photo_in glitch 1 cycle wide (DEB=2) -> no pcount change and no wvalid.
- tcount=2, three entry pulses -> pcount=3. Final wvalid carries wtime=6 (3*4/2), with busy high for W_W+2 cycles.
- pcount=7, tcount=3, one more entry -> pcount stays 7, full=1. err_ovf=1 only when QUEUE_CTRL_ERR_EN is defined. wtime=9.
- Debounced entry and exit events landing on the same edge at pcount=4 -> pcount stays 4 and no divider run starts. Then exit from pcount=0 -> stays 0, err_unf set (when the macro is defined).
- Change tcount from 1 to 2 mid-divide at pcount=5 -> the first run is aborted. A single wvalid then shows wtime=9 (3*6/2); 15 (3*5/1) never appears. Separately, rst asserted mid-divide -> all outputs return to reset values with no wvalid.
